// File: rtl/cla_serial_add_ctrl.sv
// Byte-serial wide adder controller: sequences one external 8-bit CLA over WORDS slices.
// Optional macro CLA_SUB_EN adds a 'sub' input for two's-complement subtraction.
module cla_serial_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef CLA_SUB_EN
  input  logic                 sub,
`endif
  output logic                 ready,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  input  logic                 carry_in,
  output logic [8*WORDS-1:0]   sum,
  output logic                 carry_out,
  output logic                 done,
  output logic [7:0]           cla_a,
  output logic [7:0]           cla_b,
  output logic                 cla_ci,
  input  logic [7:0]           cla_s,
  input  logic                 cla_co
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        idx;
  logic [WORDS-1:0][7:0]   op_a;
  logic [WORDS-1:0][7:0]   op_b;
  logic [WORDS-1:0][7:0]   sum_r;
  logic                    c_reg;

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign sum   = sum_r;

  // CLA inputs are only meaningful during RUN; held at zero otherwise.
  always_comb begin
    cla_a  = '0;
    cla_b  = '0;
    cla_ci = 1'b0;
    if (state == RUN) begin
      cla_a  = op_a[idx];
      cla_b  = op_b[idx];
      cla_ci = c_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sum_r     <= '0;
      c_reg     <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a <= a;
`ifdef CLA_SUB_EN
            op_b  <= sub ? ~b : b;
            c_reg <= sub ? 1'b1 : carry_in;
`else
            op_b  <= b;
            c_reg <= carry_in;
`endif
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= cla_s;
          c_reg      <= cla_co;
          if (idx == LAST) begin
            carry_out <= cla_co;
            state     <= DONE;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Self-checking bench for cla_serial_add_ctrl with a behavioural 8-bit CLA and a result scoreboard.
module tb_cla_serial_add_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic          ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          carry_in;
  logic [W-1:0]  sum;
  logic          carry_out;
  logic          done;
  logic [7:0]    cla_a;
  logic [7:0]    cla_b;
  logic          cla_ci;
  logic [7:0]    cla_s;
  logic          cla_co;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  assign {cla_co, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {8'd0, cla_ci};

  cla_serial_add_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef CLA_SUB_EN
    .sub       (sub),
`endif
    .ready     (ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out),
    .done      (done),
    .cla_a     (cla_a),
    .cla_b     (cla_b),
    .cla_ci    (cla_ci),
    .cla_s     (cla_s),
    .cla_co    (cla_co)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, pulses start for one accept edge, records the expected result.
  task automatic start_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic ci, input logic vsub);
    logic [W-1:0] eb;
    logic         ec;
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_ready_wait"}, 64'(ready), 64'd1);
    a = va; b = vb; carry_in = ci; sub = vsub; start = 1'b1;
    eb = vsub ? ~vb : vb;
    ec = vsub ? 1'b1 : ci;
    exp_q.push_back({1'b0, va} + {1'b0, eb} + {{W{1'b0}}, ec});
    tick();
    start = 1'b0;
    check({tag, "_accepted"}, 64'(ready), 64'd0);
  endtask

  // Bounded wait for done, then latency, scoreboard, pulse-width and return-to-idle checks.
  task automatic finish_op(input string tag, output logic ci_slice1);
    logic [W:0] exp;
    int n = 0;
    ci_slice1 = 1'bx;
    while (done !== 1'b1 && n < 3 * WORDS) begin
      tick();
      n++;
      if (n == 1) ci_slice1 = cla_ci;
    end
    check({tag, "_latency"}, 64'(n), 64'(WORDS));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
      check({tag, "_carry_out"}, 64'(carry_out), 64'(exp[W]));
    end
    check({tag, "_done_busy_ready"}, 64'(ready), 64'd0);
    tick();
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_back_idle"}, 64'(ready), 64'd1);
    check({tag, "_sum_hold"}, 64'(sum), 64'(exp[W-1:0]));
  endtask

  initial begin
    logic ci1;
    int   saved;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry_out", 64'(carry_out), 64'd0);
    check("rst_cla_a", 64'(cla_a), 64'd0);
    check("rst_cla_ci", 64'(cla_ci), 64'd0);

    // Test 1: carry crosses from slice 0 into slice 1
    start_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    finish_op("t1", ci1);
    check("t1_cla_ci_slice1", 64'(ci1), 64'd1);
    check("t1_done_count", 64'(done_cnt), 64'd1);

    // Test 2: full ripple and a mixed-carry case with carry_in
    start_op("t2a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    finish_op("t2a", ci1);
    start_op("t2b", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    finish_op("t2b", ci1);
    check("t2b_sum_const", 64'(sum), 64'h2345_678A);

    // Test 3: start held high; operand changes after accept must not leak in
    a = 32'd1; b = 32'd2; carry_in = 1'b0; start = 1'b1;
    exp_q.push_back(33'd3);
    tick();
    check("t3_accepted", 64'(ready), 64'd0);
    a = 32'd100; b = 32'd100;
    finish_op("t3a", ci1);
    exp_q.push_back(33'd200);
    tick();
    start = 1'b0;
    check("t3_reaccept", 64'(ready), 64'd0);
    finish_op("t3b", ci1);

    // Test 4: reset in the middle of RUN discards the operation
    saved = done_cnt;
    a = 32'h0101_0101; b = 32'h0202_0202; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("t4_running", 64'(ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4_ready", 64'(ready), 64'd1);
    check("t4_sum", 64'(sum), 64'd0);
    check("t4_carry_out", 64'(carry_out), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    repeat (10) tick();
    check("t4_no_done", 64'(done_cnt), 64'(saved));

    // Test 5: back-to-back operations
    start_op("t5a", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    finish_op("t5a", ci1);
    start_op("t5b", 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    finish_op("t5b", ci1);
    check("t5_done_count", 64'(done_cnt), 64'(saved + 2));

`ifdef CLA_SUB_EN
    // Test 6: subtraction with and without borrow
    start_op("t6a", 32'd5, 32'd7, 1'b0, 1'b1);
    finish_op("t6a", ci1);
    check("t6a_sum_const", 64'(sum), 64'hFFFF_FFFE);
    start_op("t6b", 32'd7, 32'd5, 1'b0, 1'b1);
    finish_op("t6b", ci1);
    check("t6b_carry_const", 64'(carry_out), 64'd1);
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
